// File: rtl/reg_bank_mxn_pkg.sv
// Shared helpers for the register bank and the m-to-n mux it feeds:
// bank depth and the flattened-bus slice offset for register j.
package reg_bank_mxn_pkg;

  function automatic int num_regs(input int s_lines);
    return 1 << s_lines;
  endfunction

  function automatic int slice_lo(input int d_width, input int j);
    return d_width * j;
  endfunction

endpackage

// File: rtl/reg_bank_mxn_reg_cell.sv
// One bank register with its written-since-clear flag.
// The valid flag returns to valid_init on reset and on clear.
module reg_cell #(
  parameter int d_width    = 1,
  parameter bit valid_init = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               we,
  input  logic [d_width-1:0] wdata,
  output logic [d_width-1:0] data,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= valid_init;
    end else if (clr) begin
      data  <= '0;
      valid <= valid_init;
    end else if (we) begin
      data  <= wdata;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank_mxn.sv
// Register bank feeding the m-to-n mux: flattened contents, registered
// read select, per-register written flags and a count of written registers.
module reg_bank_mxn
  import reg_bank_mxn_pkg::*;
#(
  parameter int s_lines  = 4,
  parameter int d_width  = 1,
  parameter int zero_reg = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  input  logic                                we,
  input  logic [s_lines-1:0]                  waddr,
  input  logic [d_width-1:0]                  wdata,
  input  logic                                ren,
  input  logic [s_lines-1:0]                  rsel,
  output logic [d_width*(2**s_lines)-1:0]     regs_flat,
  output logic [s_lines-1:0]                  sel_q,
  output logic [(2**s_lines)-1:0]             valid_flat,
  output logic [s_lines:0]                    wr_count,
  output logic                                all_valid
);

  localparam int NUM_REGS = num_regs(s_lines);
  localparam logic [s_lines:0] FULL     = (s_lines+1)'(NUM_REGS);
  // A hardwired register 0 counts as written from reset onwards.
  localparam logic [s_lines:0] CNT_INIT = (zero_reg != 0) ? (s_lines+1)'(1) : '0;

  logic [NUM_REGS-1:0] cell_we;
  logic [NUM_REGS-1:0] valid;
  logic                fresh_write;
  logic [s_lines:0]    next_count;

  for (genvar j = 0; j < NUM_REGS; j++) begin : g_cell
    assign cell_we[j] = we && !clr && (waddr == s_lines'(j)) && !((zero_reg != 0) && (j == 0));

    reg_cell #(
      .d_width   (d_width),
      .valid_init((zero_reg != 0) && (j == 0))
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .we   (cell_we[j]),
      .wdata(wdata),
      .data (regs_flat[slice_lo(d_width, j) +: d_width]),
      .valid(valid[j])
    );
  end

  assign valid_flat  = valid;
  // Only a write to a not-yet-valid register grows the count.
  assign fresh_write = |(cell_we & ~valid);

  always_comb begin
    next_count = wr_count;
    if (clr)
      next_count = CNT_INIT;
    else if (fresh_write)
      next_count = wr_count + (s_lines+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count  <= CNT_INIT;
      all_valid <= (CNT_INIT == FULL);
      sel_q     <= '0;
    end else begin
      wr_count  <= next_count;
      all_valid <= (next_count == FULL);
      if (ren)
        sel_q <= rsel;
    end
  end

endmodule

// File: tb/tb_reg_bank_mxn.sv
// Bench for reg_bank_mxn: two 16x8 banks (plain and zero_reg) share stimulus;
// a model-built expected snapshot is queued per edge and checked by a monitor.
module tb_reg_bank_mxn;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr, we, ren;
  logic [3:0]   waddr, rsel;
  logic [7:0]   wdata;

  logic [127:0] regs_a, regs_b;
  logic [3:0]   sel_a, sel_b;
  logic [15:0]  val_a, val_b;
  logic [4:0]   cnt_a, cnt_b;
  logic         av_a, av_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [127:0] regs_a;
    logic [15:0]  val_a;
    logic [4:0]   cnt_a;
    logic         av_a;
    logic [3:0]   sel;
    logic [127:0] regs_b;
    logic [15:0]  val_b;
    logic [4:0]   cnt_b;
    logic         av_b;
  } snap_t;
  localparam int W = $bits(snap_t);
  logic [W-1:0] exp_q[$];

  // Model state: index 0 = plain bank, 1 = zero_reg bank.
  logic [7:0]  m_reg[2][16];
  logic [15:0] m_val[2];
  logic [3:0]  m_sel;

  reg_bank_mxn #(.s_lines(4), .d_width(8), .zero_reg(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .ren(ren), .rsel(rsel), .regs_flat(regs_a), .sel_q(sel_a),
    .valid_flat(val_a), .wr_count(cnt_a), .all_valid(av_a));

  reg_bank_mxn #(.s_lines(4), .d_width(8), .zero_reg(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .ren(ren), .rsel(rsel), .regs_flat(regs_b), .sel_q(sel_b),
    .valid_flat(val_b), .wr_count(cnt_b), .all_valid(av_b));

  // Clock and reset
  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model
  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) m_reg[b][i] = 8'h00;
      m_val[b] = (b == 1) ? 16'h0001 : 16'h0000;
    end
    m_sel = 4'd0;
  endtask

  function automatic logic [127:0] flat(input int b);
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = m_reg[b][i];
    return f;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.regs_a = flat(0);
    s.val_a  = m_val[0];
    s.cnt_a  = 5'($countones(m_val[0]));
    s.av_a   = (m_val[0] == 16'hFFFF);
    s.sel    = m_sel;
    s.regs_b = flat(1);
    s.val_b  = m_val[1];
    s.cnt_b  = 5'($countones(m_val[1]));
    s.av_b   = (m_val[1] == 16'hFFFF);
    return s;
  endfunction

  // Driver: one edge of stimulus, then queue the expected post-edge state.
  task automatic op(input logic c, input logic w, input logic [3:0] a, input logic [7:0] d,
                    input logic r, input logic [3:0] rs);
    @(negedge clk);
    clr = c; we = w; waddr = a; wdata = d; ren = r; rsel = rs;
    @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++) begin
      if (c) begin
        for (int i = 0; i < 16; i++) m_reg[b][i] = 8'h00;
        m_val[b] = (b == 1) ? 16'h0001 : 16'h0000;
      end else if (w && !(b == 1 && a == 4'd0)) begin
        m_reg[b][a] = d;
        m_val[b][a] = 1'b1;
      end
    end
    if (r) m_sel = rs;
    exp_q.push_back(W'(model_snap()));
    clr = 1'b0; we = 1'b0; ren = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    op(1'b0, 1'b1, a, d, 1'b0, 4'd0);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < 10);
    check("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_regs_a"}, regs_a, 128'd0);
    check({tag, "_val_a"},  128'(val_a), 128'd0);
    check({tag, "_cnt_a"},  128'(cnt_a), 128'd0);
    check({tag, "_sel_a"},  128'(sel_a), 128'd0);
    check({tag, "_av_a"},   128'(av_a), 128'd0);
    check({tag, "_regs_b"}, regs_b, 128'd0);
    check({tag, "_val_b"},  128'(val_b), 128'h1);
    check({tag, "_cnt_b"},  128'(cnt_b), 128'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      e = snap_t'(exp_q.pop_front());
      check("regs_a", regs_a, e.regs_a);
      check("valid_a", 128'(val_a), 128'(e.val_a));
      check("count_a", 128'(cnt_a), 128'(e.cnt_a));
      check("all_valid_a", 128'(av_a), 128'(e.av_a));
      check("sel_a", 128'(sel_a), 128'(e.sel));
      check("regs_b", regs_b, e.regs_b);
      check("valid_b", 128'(val_b), 128'(e.val_b));
      check("count_b", 128'(cnt_b), 128'(e.cnt_b));
      check("all_valid_b", 128'(av_b), 128'(e.av_b));
      check("sel_b", 128'(sel_b), 128'(e.sel));
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; ren = 1'b0;
    waddr = 4'd0; rsel = 4'd0; wdata = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Write then load the read select
    wr(4'd3, 8'hA5);
    op(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3);
    drain();
    check("wr_byte3", 128'(regs_a[31:24]), 128'hA5);
    check("wr_sel", 128'(sel_a), 128'd3);
    check("wr_valid", 128'(val_a), 128'h0008);
    check("wr_count", 128'(cnt_a), 128'd1);

    // Rewrites keep the count
    wr(4'd3, 8'h5A);
    wr(4'd3, 8'h11);
    drain();
    check("rewrite_byte3", 128'(regs_a[31:24]), 128'h11);
    check("rewrite_count", 128'(cnt_a), 128'd1);

    // Same-edge write and select of one address; ren=0 edges hold sel
    op(1'b0, 1'b1, 4'd5, 8'h3C, 1'b1, 4'd5);
    wr(4'd7, 8'h99);
    drain();
    check("same_edge_byte5", 128'(regs_a[47:40]), 128'h3C);
    check("same_edge_sel", 128'(sel_a), 128'd5);

    // Fill all 16, then 5 more writes with no further change in count
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h10 + 8'(i));
    drain();
    check("fill_count", 128'(cnt_a), 128'd16);
    check("fill_all_valid", 128'(av_a), 128'd1);
    for (int i = 0; i < 5; i++) wr(4'(i), 8'hC0 + 8'(i));
    drain();
    check("sat_count", 128'(cnt_a), 128'd16);
    check("sat_all_valid", 128'(av_a), 128'd1);

    // Clear beats write; select still loads
    op(1'b1, 1'b1, 4'd2, 8'hFF, 1'b1, 4'd2);
    drain();
    check("clr_regs", regs_a, 128'd0);
    check("clr_valid", 128'(val_a), 128'd0);
    check("clr_count", 128'(cnt_a), 128'd0);
    check("clr_all_valid", 128'(av_a), 128'd0);
    check("clr_sel", 128'(sel_a), 128'd2);

    // Hardwired register 0
    wr(4'd0, 8'h77);
    drain();
    check("zr_byte0_b", 128'(regs_b[7:0]), 128'h00);
    check("zr_valid_b", 128'(val_b), 128'h0001);
    check("zr_count_b", 128'(cnt_b), 128'd1);
    check("zr_byte0_a", 128'(regs_a[7:0]), 128'h77);

    // Asynchronous reset mid-cycle, released mid-cycle
    wr(4'd9, 8'h42);
    op(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd9);
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_reset_values("rst_release");
    wr(4'd1, 8'hE1);
    drain();
    check("post_rst_byte1", 128'(regs_a[15:8]), 128'hE1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_bank_mxn.md
Name: reg_bank_mxn

Overview:
Parameterized register bank that sits directly upstream of the parameterized m-to-n multiplexer. It holds 2**s_lines registers of d_width bits and presents them as one flattened bus, with register j in slice [d_width*j + d_width-1 : d_width*j], matching the mux input indexing. It also registers the read select so that the select and the bank contents reach the mux on the same cycle boundary. It tracks which registers have been written since reset or clear, and counts them.

Parameters:
s_lines, 4, number of address bits; the bank holds 2**s_lines registers
d_width, 1, register width in bits
zero_reg, 0, when 1, register 0 is hardwired to zero and ignores writes

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear of all registers and valid bits
we  input  1  write enable
waddr  input  s_lines  write address
wdata  input  d_width  write data
ren  input  1  read-select load enable
rsel  input  s_lines  read select, captured when ren=1
regs_flat  output  d_width*2**s_lines  flattened register contents; drives the mux "in"
sel_q  output  s_lines  registered read select; drives the mux "sel"
valid_flat  output  2**s_lines  bit j=1 when register j has been written since the last reset or clr
wr_count  output  s_lines+1  number of set bits in valid_flat
all_valid  output  1  high when wr_count == 2**s_lines

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately with no clock edge):
  - all registers 0; sel_q 0; wr_count 0; all_valid 0.
  - valid_flat 0, except bit 0 = 1 when zero_reg=1; in that case wr_count resets to 1.
- Reset released mid-operation: state stays at reset values; the first update is on the next rising edge with rst_n=1.
- Priority per edge: clr > we.
  - clr=1: same values as reset; any write on that edge is dropped.
  - sel_q still loads on a clr edge if ren=1; clr does not touch sel_q.
- Write (we=1, clr=0):
  - reg[waddr] <= wdata; valid_flat[waddr] <= 1.
  - wr_count increments by 1 only if valid_flat[waddr] was 0 before the edge. Rewriting a valid register leaves the count unchanged.
- zero_reg=1 and waddr=0: the write is ignored entirely; reg 0 stays 0 and the count is unchanged.
- Latency:
  - written data appears on regs_flat on the edge after we, with no same-cycle bypass.
  - sel_q updates on the edge after ren=1; it holds its value while ren=0.
  - A write and an ren to the same address on the same edge: both take effect, so the mux output shows the new data after that edge.
- wr_count saturates naturally at 2**s_lines (all bits valid); no wrap.
  - all_valid = (wr_count == 2**s_lines), registered together with wr_count.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Widths: waddr and rsel cover the full 2**s_lines range, so there are no out-of-range addresses.

Decomposition:
- Shared package: NUM_REGS = 2**s_lines as a derived localparam, and the slice-offset function d_width*j used by both this block and the mux.
- One natural sub-module, reg_cell: a single d_width register with async active-low reset, synchronous clear, write enable and valid flag. It is generated 2**s_lines times.
- The counter, sel_q and all_valid logic stay in the top level.

Test Plan:
- Reset: with s_lines=4, d_width=8, assert rst_n=0 mid-cycle -> regs_flat=0, valid_flat=0, wr_count=0 and sel_q=0 immediately, with no clock edge.
- Write/read: write 0xA5 to addr 3, then ren with rsel=3 -> regs_flat[31:24]=0xA5 one edge after the write; sel_q=3; valid_flat=0x0008; wr_count=1.
- Rewrite: write addr 3 with 0x5A, then again with 0x11 -> regs_flat[31:24]=0x11, wr_count stays at 1.
- Fill and saturate: write all 16 addresses, then 5 more writes -> wr_count=16 and all_valid=1 after the 16th write, with no change afterwards.
- Priority: clr=1 and we=1 (addr 2, 0xFF) on the same edge -> all registers 0, valid_flat=0, wr_count=0, addr 2 not written.
- zero_reg=1: write 0x77 to addr 0 -> regs_flat[7:0]=0, valid_flat[0]=1 from reset, wr_count stays at 1.
